reg_file: RTL and testbench

REG_FILE -- requirements
Module: reg_file

---
 rtl/reg_file_pkg.sv | 13 +
 rtl/reg_file.sv | 132 +++++++++++++
 tb/tb_reg_file.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_pkg.sv
// Shared CPU defines: register-file FSM encoding and architectural constants.
package reg_file_pkg;

  // Register-file sequencing states: CLEAR zeroes the GPRs after reset, RUN is normal operation.
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } rf_state_e;

  // GPR index that is hardwired to zero.
  localparam int unsigned ZERO_REG_IDX = 0;

endpackage : reg_file_pkg

// File: rtl/reg_file.sv
// General-purpose register file with a HI/LO pair.
// After reset a sweep writes zero into every GPR. Reset itself leaves the
// array untouched so that the array can still map onto a RAM. Reads are
// combinational and bypass the write that is in flight in the same cycle.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_waddr,
  input  logic [DATA_W-1:0] wb_wdata,
  input  logic              wb_hilo_we,
  input  logic [DATA_W-1:0] wb_hi,
  input  logic [DATA_W-1:0] wb_lo,
  input  logic [ADDR_W-1:0] ra_addr,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data,
  output logic [DATA_W-1:0] hi_data,
  output logic [DATA_W-1:0] lo_data,
  output logic              busy
);

  localparam int unsigned         NUM_REGS  = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0]   ZERO_ADDR = ADDR_W'(ZERO_REG_IDX);
  localparam logic [ADDR_W-1:0]   LAST_ADDR = {ADDR_W{1'b1}};

  rf_state_e         state_q;
  logic [ADDR_W-1:0] clr_idx_q;
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;
  logic [DATA_W-1:0] gpr_q [NUM_REGS];

  logic run_s;
  logic gpr_we_s;
  logic hilo_we_s;

  // Writeback enables are only honoured in RUN, never for r0, and never alongside reset.
  assign run_s     = (state_q == ST_RUN);
  assign gpr_we_s  = run_s & wb_we & (wb_waddr != ZERO_ADDR) & ~rst;
  assign hilo_we_s = run_s & wb_hilo_we & ~rst;
  assign busy      = (state_q == ST_CLEAR);

  // Sequencer: reset restarts the clear sweep; RUN owns the HI/LO pair.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_CLEAR;
      clr_idx_q <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          if (clr_idx_q == LAST_ADDR) begin
            // Index holds at its final value for the rest of RUN.
            state_q <= ST_RUN;
          end else begin
            clr_idx_q <= clr_idx_q + ADDR_W'(1);
          end
        end
        ST_RUN: begin
          if (hilo_we_s) begin
            hi_q <= wb_hi;
            lo_q <= wb_lo;
          end
        end
        default: begin
          state_q   <= ST_CLEAR;
          clr_idx_q <= '0;
        end
      endcase
    end
  end

  // GPR array write port: sweep zeroes in CLEAR, writeback data in RUN; no reset term.
  always_ff @(posedge clk) begin
    if (!rst && !run_s) begin
      gpr_q[clr_idx_q] <= '0;
    end else if (gpr_we_s) begin
      gpr_q[wb_waddr] <= wb_wdata;
    end
  end

  // Read port A: zero while clearing or for r0, otherwise storage with write-through bypass.
  always_comb begin
    ra_data = '0;
    if (run_s && (ra_addr != ZERO_ADDR)) begin
      if (gpr_we_s && (wb_waddr == ra_addr)) begin
        ra_data = wb_wdata;
      end else begin
        ra_data = gpr_q[ra_addr];
      end
    end else begin
      ra_data = '0;
    end
  end

  // Read port B: same rules as port A so both agree on a shared address.
  always_comb begin
    rb_data = '0;
    if (run_s && (rb_addr != ZERO_ADDR)) begin
      if (gpr_we_s && (wb_waddr == rb_addr)) begin
        rb_data = wb_wdata;
      end else begin
        rb_data = gpr_q[rb_addr];
      end
    end else begin
      rb_data = '0;
    end
  end

  // HI/LO view: zero while clearing, bypassed during a pair write.
  always_comb begin
    hi_data = '0;
    lo_data = '0;
    if (!run_s) begin
      hi_data = '0;
      lo_data = '0;
    end else if (hilo_we_s) begin
      hi_data = wb_hi;
      lo_data = wb_lo;
    end else begin
      hi_data = hi_q;
      lo_data = lo_q;
    end
  end

endmodule : reg_file

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: behavioural model feeding a scoreboard
// queue, plus directed checks with fixed expected values.
module tb_reg_file;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          wb_we;
  logic [AW-1:0] wb_waddr;
  logic [DW-1:0] wb_wdata;
  logic          wb_hilo_we;
  logic [DW-1:0] wb_hi;
  logic [DW-1:0] wb_lo;
  logic [AW-1:0] ra_addr;
  logic [AW-1:0] rb_addr;
  logic [DW-1:0] ra_data;
  logic [DW-1:0] rb_data;
  logic [DW-1:0] hi_data;
  logic [DW-1:0] lo_data;
  logic          busy;

  always #5 clk = ~clk;

  reg_file #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .wb_hilo_we(wb_hilo_we), .wb_hi(wb_hi), .wb_lo(wb_lo),
    .ra_addr(ra_addr), .rb_addr(rb_addr),
    .ra_data(ra_data), .rb_data(rb_data),
    .hi_data(hi_data), .lo_data(lo_data),
    .busy(busy)
  );

  typedef struct {
    string         tag;
    logic [DW-1:0] val;
  } exp_t;

  exp_t          sb_q[$];
  int            n_checks = 0;
  int            n_err    = 0;

  // Reference model state
  logic [DW-1:0] m_gpr [NR];
  logic [DW-1:0] m_hi, m_lo;
  bit            m_clear = 1'b1;
  int            m_idx   = 0;
  bit            m_live  = 1'b0;

  task automatic check_eq(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a);
    if (m_clear || a == '0) return '0;
    if (wb_we && wb_waddr == a) return wb_wdata;
    return m_gpr[a];
  endfunction

  // Push model expectations for the current inputs, let logic settle, pop and compare.
  task automatic settle();
    exp_t e;
    if (m_live) begin
      sb_q.push_back('{"ra", m_read(ra_addr)});
      sb_q.push_back('{"rb", m_read(rb_addr)});
      sb_q.push_back('{"hi", m_clear ? '0 : (wb_hilo_we ? wb_hi : m_hi)});
      sb_q.push_back('{"lo", m_clear ? '0 : (wb_hilo_we ? wb_lo : m_lo)});
      sb_q.push_back('{"busy", DW'(m_clear)});
    end
    #1;
    if (sb_q.size() == 5) begin
      e = sb_q.pop_front(); check_eq(e.tag, ra_data, e.val);
      e = sb_q.pop_front(); check_eq(e.tag, rb_data, e.val);
      e = sb_q.pop_front(); check_eq(e.tag, hi_data, e.val);
      e = sb_q.pop_front(); check_eq(e.tag, lo_data, e.val);
      e = sb_q.pop_front(); check_eq(e.tag, DW'(busy), e.val);
    end
  endtask

  // Clock edge; the model follows the same inputs the DUT sampled.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_clear = 1'b1; m_idx = 0; m_hi = '0; m_lo = '0; m_live = 1'b1;
    end else if (m_clear) begin
      m_gpr[m_idx] = '0;
      if (m_idx == NR - 1) m_clear = 1'b0;
      else m_idx++;
    end else begin
      if (wb_we && wb_waddr != '0) m_gpr[wb_waddr] = wb_wdata;
      if (wb_hilo_we) begin m_hi = wb_hi; m_lo = wb_lo; end
    end
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; wb_we = 1'b0; wb_waddr = '0; wb_wdata = '0;
    wb_hilo_we = 1'b0; wb_hi = '0; wb_lo = '0;
  endtask

  // Count busy cycles until RUN; stops in the first RUN cycle, before its edge.
  task automatic count_sweep(input string tag);
    int n = 0;
    for (int k = 0; k < 100; k++) begin
      ra_addr = AW'(k); rb_addr = AW'(NR - 1 - (k % NR));
      settle();
      if (busy !== 1'b1) break;
      n++;
      tick();
    end
    check_eq(tag, DW'(n), DW'(32));
  endtask

  initial begin
    for (int i = 0; i < NR; i++) m_gpr[i] = '0;
    m_hi = '0; m_lo = '0;
    idle(); ra_addr = '0; rb_addr = '0;

    // Power-up reset
    rst = 1'b1; tick(); tick();
    rst = 1'b0;
    count_sweep("busy_len_init");

    // First RUN cycle: write r31
    wb_we = 1'b1; wb_waddr = 5'd31; wb_wdata = 32'hA5A5A5A5; ra_addr = 5'd31; rb_addr = 5'd0;
    settle(); tick(); idle();
    settle(); check_eq("r31_hold", ra_data, 32'hA5A5A5A5); tick();

    // All registers except r31 read zero after the sweep
    for (int i = 0; i < NR / 2 - 1; i++) begin
      ra_addr = AW'(2 * i); rb_addr = AW'(2 * i + 1);
      settle();
      check_eq("clr_ra", ra_data, 32'h0);
      check_eq("clr_rb", rb_data, 32'h0);
      tick();
    end

    // Bypass on both ports, then stored value
    wb_we = 1'b1; wb_waddr = 5'd5; wb_wdata = 32'hDEADBEEF; ra_addr = 5'd5; rb_addr = 5'd5;
    settle();
    check_eq("byp_ra5", ra_data, 32'hDEADBEEF);
    check_eq("byp_rb5", rb_data, 32'hDEADBEEF);
    tick(); idle();
    settle();
    check_eq("st_ra5", ra_data, 32'hDEADBEEF);
    check_eq("st_rb5", rb_data, 32'hDEADBEEF);
    tick();

    // r0 write is discarded
    wb_we = 1'b1; wb_waddr = 5'd0; wb_wdata = 32'hFFFFFFFF; ra_addr = 5'd0; rb_addr = 5'd0;
    settle(); check_eq("r0_byp", ra_data, 32'h0); tick(); idle();
    for (int i = 0; i < 3; i++) begin
      settle(); check_eq("r0_later", ra_data, 32'h0); tick();
    end

    // HI/LO and GPR write in the same cycle
    wb_hilo_we = 1'b1; wb_hi = 32'h12345678; wb_lo = 32'h9ABCDEF0;
    wb_we = 1'b1; wb_waddr = 5'd7; wb_wdata = 32'h0000_7777; ra_addr = 5'd7; rb_addr = 5'd5;
    settle();
    check_eq("hi_byp", hi_data, 32'h12345678);
    check_eq("lo_byp", lo_data, 32'h9ABCDEF0);
    tick(); idle();
    settle();
    check_eq("r7_st", ra_data, 32'h0000_7777);
    check_eq("hi_st", hi_data, 32'h12345678);
    check_eq("lo_st", lo_data, 32'h9ABCDEF0);
    tick();

    // Random traffic checked by the model
    for (int i = 0; i < 150; i++) begin
      wb_we      = 1'($urandom_range(0, 1));
      wb_waddr   = AW'($urandom_range(0, NR - 1));
      wb_wdata   = DW'($urandom);
      wb_hilo_we = ($urandom_range(0, 3) == 0);
      wb_hi      = DW'($urandom);
      wb_lo      = DW'($urandom);
      ra_addr    = ($urandom_range(0, 3) == 0) ? wb_waddr : AW'($urandom_range(0, NR - 1));
      rb_addr    = ($urandom_range(0, 2) == 0) ? ra_addr : AW'($urandom_range(0, NR - 1));
      settle(); tick();
    end
    idle();

    // Write r3, reset from RUN, reset again mid-sweep while attempting writes
    wb_we = 1'b1; wb_waddr = 5'd3; wb_wdata = 32'h11; ra_addr = 5'd3; rb_addr = 5'd3;
    settle(); tick(); idle();
    settle(); check_eq("r3_pre", ra_data, 32'h11); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      wb_we = 1'b1; wb_waddr = 5'd3; wb_wdata = 32'h22;
      wb_hilo_we = 1'b1; wb_hi = 32'hBAD0BAD0; wb_lo = 32'h0BAD0BAD;
      settle(); tick();
    end
    rst = 1'b1; settle(); tick(); idle();
    wb_we = 1'b1; wb_waddr = 5'd3; wb_wdata = 32'h22;
    count_sweep("busy_len_rst");
    idle(); ra_addr = 5'd3; rb_addr = 5'd31;
    settle();
    check_eq("r3_clr", ra_data, 32'h0);
    check_eq("r31_clr", rb_data, 32'h0);
    check_eq("hi_clr", hi_data, 32'h0);
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule : tb_reg_file
